// File: rtl/next_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : next_serial_tx_if
// Description : Host-side request/status bundle of the NeXT 40-bit serial
//               transmitter.
//   data        40  packet payload, bit 39 sent first
//   send         1  request to send data (held until ready)
//   send_reset   1  request to send the all-ones reset packet
//   ready        1  transmitter idle, accepts a request this edge
//   so           1  registered serial output
//   busy         1  packet or guard gap in progress
//   done         1  one-cycle pulse when a packet's gap completes
//   master : host command logic      slave : transmitter
// Revision    : 1.0  initial release
// ============================================================================
interface next_serial_tx_if;
    logic [39:0] data;
    logic        send;
    logic        send_reset;
    logic        ready;
    logic        so;
    logic        busy;
    logic        done;

    modport master (
        output data, send, send_reset,
        input  ready, so, busy, done
    );

    modport slave (
        input  data, send, send_reset,
        output ready, so, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/next_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : next_serial_tx
// Description : Transmitter for the 40-bit NeXT keyboard/sound link. Sends a
//               one-cycle high start bit, 40 data bits MSB first, then a low
//               guard gap; or a long all-ones reset packet followed by the gap.
//               The line idles low.
// Ports       :
//   clk   in   system clock, one bit per clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of next_serial_tx_if (data/send/send_reset in,
//              ready/so/busy/done out)
// Parameters  :
//   GAP_BITS     low cycles after each packet (2..15)
//   RESET_EXTRA  extra high cycles after the 41 of a reset packet (2..23)
// Revision    : 1.0  initial release
// ============================================================================
module next_serial_tx #(
    parameter int GAP_BITS    = 2,
    parameter int RESET_EXTRA = 2
) (
    input  logic             clk,
    input  logic             rst,
    next_serial_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_RSTHOLD = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Terminal counts; the counter always leaves its state on these values,
    // so it never rolls over.
    localparam logic [5:0] c_DATA_LAST = 6'd39;
    localparam logic [5:0] c_RST_LAST  = 6'(40 + RESET_EXTRA);
    localparam logic [5:0] c_GAP_LAST  = 6'(GAP_BITS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] shreg_q, shreg_d;
    logic        so_q, so_d;
    logic        done_q, done_d;

    // so_d is derived from the state being left at each edge, so the line
    // trails the state by one cycle: the START state is entered at the
    // acceptance edge and the start bit appears on so one edge later. The
    // last gap zero therefore coincides with the first IDLE cycle, which is
    // also where done pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        so_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.send_reset || bus.send) begin
                    shreg_d = bus.data;
                    cnt_d   = 6'd0;
                    // Reset request wins; a simultaneous send is dropped.
                    state_d = bus.send_reset ? S_RSTHOLD : S_START;
                end
            end

            S_START: begin
                so_d    = 1'b1;
                cnt_d   = 6'd0;
                state_d = S_DATA;
            end

            S_DATA: begin
                so_d    = shreg_q[39];
                shreg_d = {shreg_q[38:0], 1'b0};
                if (cnt_q == c_DATA_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_RSTHOLD: begin
                so_d = 1'b1;
                if (cnt_q == c_RST_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d   = 6'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            default: begin
                cnt_d   = 6'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            shreg_q <= 40'd0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.so    = so_q;
    assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_next_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_next_serial_tx
// Description : Self-checking bench for next_serial_tx. Table of packet
//               requests with expected line waveforms built from the packet
//               format, plus hand sequences for back-to-back sends and a
//               mid-packet reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_next_serial_tx;

    localparam int c_GAP = 2;
    localparam int c_RE  = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    next_serial_tx_if bus ();

    next_serial_tx #(
        .GAP_BITS    (c_GAP),
        .RESET_EXTRA (c_RE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] data;
        bit          snd;
        bit          srst;
        logic [39:0] data_late;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int idx);
        int t;
        t = 0;
        while (bus.ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.ready !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_timeout%0d: got ready=%b expected 1", idx, bus.ready);
        end
    endtask

    // Line waveform indexed by cycle k after the acceptance edge (k>=1).
    function automatic logic [127:0] exp_so(input logic [39:0] d, input bit is_rst);
        logic [127:0] e;
        e = '0;
        if (is_rst) begin
            for (int k = 1; k <= 41 + c_RE; k++) e[k] = 1'b1;
        end else begin
            e[1] = 1'b1;
            for (int i = 0; i < 40; i++) e[2 + i] = d[39 - i];
        end
        return e;
    endfunction

    task automatic collect(input int n, output logic [127:0] s,
                           output logic [127:0] dn, output logic [127:0] rd);
        s = '0; dn = '0; rd = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            s[k]  = bus.so;
            dn[k] = bus.done;
            rd[k] = bus.ready;
        end
    endtask

    task automatic run_packet(input int idx, input logic [39:0] d, input bit snd,
                              input bit srst, input logic [39:0] late);
        int total;
        int run;
        logic [127:0] s, dn, rd;
        logic [39:0] pay;
        wait_ready(idx);
        bus.data       = d;
        bus.send       = snd;
        bus.send_reset = srst;
        @(posedge clk);
        @(negedge clk);
        bus.send       = 1'b0;
        bus.send_reset = 1'b0;
        bus.data       = late;
        check($sformatf("accept%0d {so,busy}", idx), {126'd0, bus.so, bus.busy}, 128'b01);
        total = (srst ? 41 + c_RE : 41) + c_GAP;
        collect(total, s, dn, rd);
        check($sformatf("so_stream%0d", idx), s, exp_so(d, srst));
        check($sformatf("done_pulse%0d", idx), dn, 128'b1 << total);
        check($sformatf("ready_rise%0d", idx), rd, 128'b1 << total);
        // Receiver-side view: a run of 42+ highs is a reset request.
        run = 0;
        while (run < 120 && s[run + 1]) run++;
        check($sformatf("rx_reset%0d", idx), {127'd0, (run >= 42)}, {127'd0, srst});
        if (!srst) begin
            for (int i = 0; i < 40; i++) pay[39 - i] = s[2 + i];
            check($sformatf("rx_data%0d", idx), {88'd0, pay}, {88'd0, d});
        end
    endtask

    vec_t vecs [5];

    initial begin
        logic [127:0] s, dn, rd, es;
        logic [39:0] pay;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{40'hA9F0AAAAA9, 1'b1, 1'b0, 40'h0};
        vecs[1] = '{40'h0123456789, 1'b1, 1'b1, 40'h0};
        vecs[2] = '{40'hFFFFFFFFFF, 1'b1, 1'b0, 40'h0};
        vecs[3] = '{40'h0000000000, 1'b0, 1'b1, 40'hFFFFFFFFFF};
        vecs[4] = '{40'h8000000001, 1'b1, 1'b0, 40'h7FFFFFFFFE};

        bus.data       = '0;
        bus.send       = 1'b0;
        bus.send_reset = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("idle%0d {so,ready,busy,done}", k),
                  {124'd0, bus.so, bus.ready, bus.busy, bus.done}, 128'b0100);
        end

        // Table of single packets
        for (int i = 0; i < 5; i++)
            run_packet(i, vecs[i].data, vecs[i].snd, vecs[i].srst, vecs[i].data_late);

        // Back-to-back: send held high across two packets
        wait_ready(10);
        bus.data = 40'h00000000FF;
        bus.send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = '0; dn = '0; rd = '0;
        for (int k = 1; k <= 87; k++) begin
            @(negedge clk);
            s[k]  = bus.so;
            dn[k] = bus.done;
            if (k == 44) bus.send = 1'b0;
        end
        es = exp_so(40'h00000000FF, 1'b0) | (exp_so(40'h00000000FF, 1'b0) << 44);
        check("b2b so_stream", s, es);
        check("b2b done_pulses", dn, (128'b1 << 43) | (128'b1 << 87));
        for (int i = 0; i < 40; i++) pay[39 - i] = s[46 + i];
        check("b2b rx_data2", {88'd0, pay}, {88'd0, 40'h00000000FF});

        // Mid-packet reset
        wait_ready(11);
        bus.data = 40'hA9F0AAAAA9;
        bus.send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.send = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("pre_abort so", {127'd0, bus.so}, 128'd1);
        rst = 1'b1;
        #1;
        check("abort {so,ready,busy,done}",
              {124'd0, bus.so, bus.ready, bus.busy, bus.done}, 128'b0100);
        @(negedge clk);
        rst = 1'b0;
        run_packet(12, 40'h5555555555, 1'b1, 1'b0, 40'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
